ti_sbox_sched: RTL and testbench
================================

# ti_sbox_sched

Scheduler that runs one S-box layer over a 64-bit masked state by serialising its 16 nibbles through a single shared, pipelined threshold-implementation (TI) S-box datapath. The datapath is built from the share component functions and sits outside this block. For each nibble the block:
- refreshes the input shares with fresh randomness;
- issues the nibble to the datapath;
- writes the datapath result back into the state register in place.

The block sits between the round-state register file and the TI S-box instance in the masked cipher core.

## Interface
Parameters:
- `NIBBLES`, 16: nibbles per state; the state width is `4*NIBBLES`.
- `SHARES`, 3: Boolean shares per bit.
- `LAT`, 2: fixed latency of the external S-box datapath, in cycles, from `sbox_x_vld` to the matching `sbox_y`; range 1..4.

Ports (`RW = 4*(SHARES-1)`, `SW = SHARES*4*NIBBLES`):
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `load`  in  1  write `state_in` into the state register; acted on only while idle.
- `state_in`  in  SW  shared state; share s, nibble i sits at bits `[s*4*NIBBLES+4i+3 : s*4*NIBBLES+4i]`.
- `start`  in  1  begin one S-box layer; acted on only while idle and `load`=0.
- `busy`  out  1  a layer is in progress.
- `done`  out  1  one-cycle pulse when the layer completes.
- `state_out`  out  SW  state register, always visible.
- `rnd_rdy`  out  1  the block can accept randomness.
- `rnd_vld`  in  1  randomness is valid.
- `rnd`  in  RW  fresh mask bits for one nibble.
- `sbox_x`  out  4*SHARES  shared S-box input; share s at `[4s+3:4s]`. Registered.
- `sbox_x_vld`  out  1  `sbox_x` is valid this cycle. Registered.
- `sbox_y`  in  4*SHARES  shared S-box output, same share layout as `sbox_x`.

## Operation
- **FSM states:**
  - IDLE → FEED on `start` (while idle, `load`=0).
  - FEED → DRAIN when the handshake for nibble `NIBBLES-1` occurs.
  - DRAIN → IDLE when the last nibble is captured.
- **Feed pointer** `fi` (0..NIBBLES-1):
  - `rnd_rdy`=1 only in FEED.
  - A handshake occurs on `rnd_vld & rnd_rdy`.
  - On a handshake, nibble `fi` is read from the state register and refreshed, then registered into `sbox_x` with `sbox_x_vld`<=1, and `fi` increments.
  - With no handshake, `sbox_x_vld`<=0 and `sbox_x` holds its value (a bubble).
- **Refresh rule:**
  - For s < SHARES-1: `x_s ^= rnd[4s+3:4s]`.
  - For the last share: `x_last ^= XOR of all rnd nibbles`.
  - The unmasked value is therefore preserved.
- **Valid tracking:**
  - An internal LAT-deep shift register tracks `sbox_x_vld`.
  - When its output is 1, `sbox_y` is captured into nibble `ci` of the state register and the capture pointer `ci` increments.
  - `ci` never exceeds `fi`, so in-place writeback never corrupts a nibble that has not been fed.
- **Completion:** when capture `ci=NIBBLES-1` occurs, at that same edge:
  - `busy`<=0 and `done`<=1;
  - `fi` and `ci` reset to 0.
- **Ignored inputs:**
  - `start` and `load` are ignored while `busy`.
  - `load` has priority over `start` when both are asserted while idle; `start` is then ignored.
- **Reset** (rst_n=0 sampled at an edge) overrides everything, including mid-layer:
  - state register ← 0, `busy`=0, `done`=0, `rnd_rdy`=0, `sbox_x_vld`=0, `sbox_x`=0;
  - valid pipeline, `fi` and `ci` cleared; FSM → IDLE;
  - in-flight datapath results are discarded and never captured.

## Timing
- The reset value of every output is 0.
- `start` sampled at edge E0 → `busy`=1 and `rnd_rdy`=1 from E0.
- **Back-to-back randomness** (`rnd_vld` held high):
  - handshakes occur at E1..E(NIBBLES);
  - `sbox_x_vld`=1 for the NIBBLES cycles following E1;
  - nibble k is captured at E(k+1+LAT+1);
  - `done`=1 for one cycle after E(NIBBLES+LAT+1); for the defaults this is E19.
- Each cycle with `rnd_vld`=0 in FEED delays completion by one cycle.
- `start` is accepted again in the cycle `done`=1, because `busy`=0 by then.
- `state_out` updates one nibble per capture edge; it is final when `done`=1.

## Test plan
- **Identity pass-through:** bench datapath model delays `sbox_x` by LAT; `rnd`=0; load state with shares = `0123456789ABCDEF`, `FEDCBA9876543210`, `0`; pulse `start` → `state_out` unchanged; `done` after E19; 16 `sbox_x_vld` pulses.
- **Refresh correctness:** same model; `rnd`=`0xA5` for every nibble → share0 nibbles ^5, share1 nibbles ^A, share2 nibbles ^F; XOR of the three shares is unchanged.
- **Stall:** drop `rnd_vld` for 3 cycles after the 5th handshake → exactly 3 bubbles on `sbox_x_vld`; `done` delayed 3 cycles (E22); result identical to the first scenario.
- **Ignored inputs:** `start` and `load` (`state_in` all-ones) asserted mid-layer → both ignored; final state as in the first scenario; `load`+`start` together while idle → load only, `busy` stays 0.
- **Reset mid-operation:** `rst_n`=0 for one edge at cycle 10 → all outputs 0, state 0; later `sbox_y` arrivals are not captured; a fresh `load`/`start` completes normally.
- **LAT=4 with a real PRESENT TI datapath:** random shared states → unmasked result equals PRESENT S-box applied per nibble; `done` at E(16+4+1)=E21.

Source files
------------

// File: rtl/ti_sbox_sched.sv
// Serialises the nibbles of a masked state through one shared, pipelined TI S-box,
// refreshing each nibble's shares on issue and writing the result back in place.
module ti_sbox_sched #(
    parameter int NIBBLES = 16,
    parameter int SHARES  = 3,
    parameter int LAT     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [SHARES*4*NIBBLES-1:0]   state_in,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [SHARES*4*NIBBLES-1:0]   state_out,
    output logic                          rnd_rdy,
    input  logic                          rnd_vld,
    input  logic [4*(SHARES-1)-1:0]       rnd,
    output logic [4*SHARES-1:0]           sbox_x,
    output logic                          sbox_x_vld,
    input  logic [4*SHARES-1:0]           sbox_y,
    output logic [1:0]                    dbg_fsm_state
);

    localparam int SW = SHARES * 4 * NIBBLES;
    localparam int PW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } fsm_t;

    fsm_t                  fsm_q;
    logic [SW-1:0]         state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  rnd_rdy_q;
    logic                  x_vld_q;
    logic [4*SHARES-1:0]   x_q;
    logic [4*SHARES-1:0]   x_d;
    logic [LAT-1:0]        vld_q;
    logic [PW-1:0]         fi_q;
    logic [PW-1:0]         ci_q;
    logic [3:0]            rnd_fold;
    logic                  hs;
    logic                  cap;

    // Handshake: a nibble is issued on an edge where rnd_vld and rnd_rdy are both high;
    // rnd_rdy is high exactly while feeding, and rnd must be stable whenever rnd_vld is.
    assign hs  = rnd_rdy_q & rnd_vld;
    assign cap = vld_q[LAT-1] & busy_q;

    // The last share absorbs the XOR of all mask nibbles so the unmasked nibble is unchanged.
    always_comb begin
        rnd_fold = '0;
        x_d      = '0;
        for (int s = 0; s < SHARES - 1; s++) begin
            rnd_fold = rnd_fold ^ rnd[4*s +: 4];
            x_d[4*s +: 4] = state_q[s*4*NIBBLES + 4*int'(fi_q) +: 4] ^ rnd[4*s +: 4];
        end
        x_d[4*(SHARES-1) +: 4] =
            state_q[(SHARES-1)*4*NIBBLES + 4*int'(fi_q) +: 4] ^ rnd_fold;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rnd_rdy_q <= 1'b0;
            x_vld_q   <= 1'b0;
            x_q       <= '0;
            vld_q     <= '0;
            fi_q      <= '0;
            ci_q      <= '0;
        end else begin
            done_q   <= 1'b0;
            vld_q[0] <= x_vld_q;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end

            case (fsm_q)
                IDLE: begin
                    x_vld_q <= 1'b0;
                    if (load) begin
                        state_q <= state_in;
                    end else if (start) begin
                        fsm_q     <= FEED;
                        busy_q    <= 1'b1;
                        rnd_rdy_q <= 1'b1;
                    end
                end
                FEED: begin
                    if (hs) begin
                        x_q     <= x_d;
                        x_vld_q <= 1'b1;
                        if (fi_q == LAST) begin
                            fsm_q     <= DRAIN;
                            rnd_rdy_q <= 1'b0;
                        end else begin
                            fi_q <= fi_q + 1'b1;
                        end
                    end else begin
                        x_vld_q <= 1'b0;
                    end
                end
                default: begin
                    x_vld_q <= 1'b0;
                end
            endcase

            // Results return in issue order, so ci trails fi and only overwrites fed nibbles.
            if (cap) begin
                for (int s = 0; s < SHARES; s++) begin
                    state_q[s*4*NIBBLES + 4*int'(ci_q) +: 4] <= sbox_y[4*s +: 4];
                end
                if (ci_q == LAST) begin
                    fsm_q  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    fi_q   <= '0;
                    ci_q   <= '0;
                end else begin
                    ci_q <= ci_q + 1'b1;
                end
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign state_out     = state_q;
    assign rnd_rdy       = rnd_rdy_q;
    assign sbox_x        = x_q;
    assign sbox_x_vld    = x_vld_q;
    assign dbg_fsm_state = fsm_q;

endmodule

// File: tb/tb_ti_sbox_sched.sv
// Directed bench for ti_sbox_sched: an identity delay-line datapath (LAT=2) and a
// functional shared PRESENT S-box datapath (LAT=4), each driving its own instance.
module tb_ti_sbox_sched;

    localparam int SW = 192;
    localparam int XW = 12;
    localparam logic [63:0]   S0_ID     = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0]   S1_ID     = 64'hFEDC_BA98_7654_3210;
    localparam logic [SW-1:0] ID_STATE  = {64'h0, S1_ID, S0_ID};
    localparam logic [SW-1:0] REF_STATE = {64'hFFFF_FFFF_FFFF_FFFF,
                                           64'h5476_1032_DCFE_98BA,
                                           64'h5476_1032_DCFE_98BA};
    localparam logic [SW-1:0] ALT_STATE = {3{64'h1357_9BDF_0246_8ACE}};

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT A (LAT=2, identity datapath) ----------------
    logic          load_a = 1'b0, start_a = 1'b0, rnd_vld_a = 1'b0;
    logic [SW-1:0] state_in_a = '0;
    logic [7:0]    rnd_a = '0;
    logic          busy_a, done_a, rnd_rdy_a, sbox_x_vld_a;
    logic [SW-1:0] state_out_a;
    logic [XW-1:0] sbox_x_a, sbox_y_a;
    logic [1:0]    dbg_a;
    logic [XW-1:0] da0, da1;

    ti_sbox_sched #(.NIBBLES(16), .SHARES(3), .LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .load(load_a), .state_in(state_in_a), .start(start_a),
        .busy(busy_a), .done(done_a), .state_out(state_out_a), .rnd_rdy(rnd_rdy_a),
        .rnd_vld(rnd_vld_a), .rnd(rnd_a), .sbox_x(sbox_x_a), .sbox_x_vld(sbox_x_vld_a),
        .sbox_y(sbox_y_a), .dbg_fsm_state(dbg_a)
    );

    always @(posedge clk) begin
        da0 <= sbox_x_a;
        da1 <= da0;
    end
    assign sbox_y_a = da1;

    // ---------------- DUT B (LAT=4, shared PRESENT datapath) ----------------
    logic          load_b = 1'b0, start_b = 1'b0, rnd_vld_b = 1'b0;
    logic [SW-1:0] state_in_b = '0;
    logic [7:0]    rnd_b = '0;
    logic          busy_b, done_b, rnd_rdy_b, sbox_x_vld_b;
    logic [SW-1:0] state_out_b;
    logic [XW-1:0] sbox_x_b, sbox_y_b;
    logic [1:0]    dbg_b;
    logic [XW-1:0] pb [4];

    ti_sbox_sched #(.NIBBLES(16), .SHARES(3), .LAT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load_b), .state_in(state_in_b), .start(start_b),
        .busy(busy_b), .done(done_b), .state_out(state_out_b), .rnd_rdy(rnd_rdy_b),
        .rnd_vld(rnd_vld_b), .rnd(rnd_b), .sbox_x(sbox_x_b), .sbox_x_vld(sbox_x_vld_b),
        .sbox_y(sbox_y_b), .dbg_fsm_state(dbg_b)
    );

    function automatic logic [3:0] present_s(input logic [3:0] v);
        case (v)
            4'h0: present_s = 4'hC;  4'h1: present_s = 4'h5;
            4'h2: present_s = 4'h6;  4'h3: present_s = 4'hB;
            4'h4: present_s = 4'h9;  4'h5: present_s = 4'h0;
            4'h6: present_s = 4'hA;  4'h7: present_s = 4'hD;
            4'h8: present_s = 4'h3;  4'h9: present_s = 4'hE;
            4'hA: present_s = 4'hF;  4'hB: present_s = 4'h8;
            4'hC: present_s = 4'h4;  4'hD: present_s = 4'h7;
            4'hE: present_s = 4'h1;  default: present_s = 4'h2;
        endcase
    endfunction

    function automatic logic [XW-1:0] shared_present(input logic [XW-1:0] x, input logic [7:0] m);
        logic [3:0] u;
        u = x[3:0] ^ x[7:4] ^ x[11:8];
        return {present_s(u) ^ m[3:0] ^ m[7:4], m[7:4], m[3:0]};
    endfunction

    always @(posedge clk) begin : model_b
        logic [7:0] m;
        m = 8'($urandom);
        pb[0] <= shared_present(sbox_x_b, m);
        for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
    end
    assign sbox_y_b = pb[3];

    // ---------------- driver tasks ----------------
    task automatic drive_load_a(input logic [SW-1:0] v);
        @(negedge clk);
        load_a = 1'b1;
        state_in_a = v;
        @(negedge clk);
        load_a = 1'b0;
    endtask

    // Runs one layer on DUT A; j counts negedges after the edge E0 that samples start.
    task automatic run_a(input bit pre_started, input int stall_len, input int inject_j,
                         input logic [7:0] rv, output int done_j, output int vld_n,
                         output int first_v, output int last_v, output logic busy0,
                         output logic rdy0);
        int hs;
        int sl;
        if (!pre_started) begin
            @(negedge clk);
            start_a = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        done_j = -1; vld_n = 0; first_v = -1; last_v = -1; hs = 0; sl = stall_len;
        rnd_a = rv;
        busy0 = busy_a;
        rdy0 = rnd_rdy_a;
        for (int j = 0; j < 60 && done_j < 0; j++) begin
            if (j > 0) @(negedge clk);
            start_a = 1'b0;
            load_a = 1'b0;
            if (sbox_x_vld_a) begin
                vld_n++;
                if (first_v < 0) first_v = j;
                last_v = j;
            end
            if (done_a) done_j = j;
            if (j == inject_j) begin
                start_a = 1'b1;
                load_a = 1'b1;
                state_in_a = '1;
            end
            if (hs == 5 && sl > 0) begin
                rnd_vld_a = 1'b0;
                sl--;
            end else begin
                rnd_vld_a = 1'b1;
            end
            if (rnd_vld_a && rnd_rdy_a) hs++;
        end
        rnd_vld_a = 1'b0;
        start_a = 1'b0;
        load_a = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
        checks++; if (rnd_rdy_a !== 1'b0) begin errors++; $display("FAIL reset_rnd_rdy: got %b expected 0", rnd_rdy_a); end
        checks++; if (sbox_x_vld_a !== 1'b0) begin errors++; $display("FAIL reset_x_vld: got %b expected 0", sbox_x_vld_a); end
        checks++; if (sbox_x_a !== 12'h000) begin errors++; $display("FAIL reset_sbox_x: got %h expected 000", sbox_x_a); end
        checks++; if (state_out_a !== '0) begin errors++; $display("FAIL reset_state: got %h expected 0", state_out_a); end
        checks++; if (dbg_a !== 2'd0) begin errors++; $display("FAIL reset_fsm: got %0d expected 0", dbg_a); end
        checks++; if (busy_b !== 1'b0 || state_out_b !== '0) begin errors++; $display("FAIL reset_b: got busy %b state %h expected 0", busy_b, state_out_b); end
        rst_n = 1'b1;
    endtask

    task automatic test_identity;
        int dj, vn, fv, lv;
        logic b0, r0;
        drive_load_a(ID_STATE);
        checks++; if (state_out_a !== ID_STATE) begin errors++; $display("FAIL id_load: got %h expected %h", state_out_a, ID_STATE); end
        run_a(1'b0, 0, -1, 8'h00, dj, vn, fv, lv, b0, r0);
        checks++; if (b0 !== 1'b1 || r0 !== 1'b1) begin errors++; $display("FAIL id_start: got busy %b rdy %b expected 1 1", b0, r0); end
        checks++; if (dj != 19) begin errors++; $display("FAIL id_done_edge: got %0d expected 19", dj); end
        checks++; if (vn != 16 || fv != 1 || lv != 16) begin errors++; $display("FAIL id_vld: got n=%0d first=%0d last=%0d expected 16 1 16", vn, fv, lv); end
        checks++; if (state_out_a !== ID_STATE) begin errors++; $display("FAIL id_state: got %h expected %h", state_out_a, ID_STATE); end
        @(negedge clk);
        checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL id_done_pulse: got done %b busy %b expected 0 0", done_a, busy_a); end
    endtask

    task automatic test_refresh;
        int dj, vn, fv, lv;
        logic b0, r0;
        drive_load_a(ID_STATE);
        run_a(1'b0, 0, -1, 8'hA5, dj, vn, fv, lv, b0, r0);
        checks++; if (dj != 19) begin errors++; $display("FAIL ref_done_edge: got %0d expected 19", dj); end
        checks++; if (state_out_a !== REF_STATE) begin errors++; $display("FAIL ref_state: got %h expected %h", state_out_a, REF_STATE); end
        checks++; if ((state_out_a[63:0] ^ state_out_a[127:64] ^ state_out_a[191:128]) !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL ref_unmasked: got %h expected ffffffffffffffff", state_out_a[63:0] ^ state_out_a[127:64] ^ state_out_a[191:128]);
        end
    endtask

    task automatic test_stall;
        int dj, vn, fv, lv;
        logic b0, r0;
        drive_load_a(ID_STATE);
        run_a(1'b0, 3, -1, 8'h00, dj, vn, fv, lv, b0, r0);
        checks++; if (dj != 22) begin errors++; $display("FAIL stall_done_edge: got %0d expected 22", dj); end
        checks++; if (vn != 16 || fv != 1 || lv != 19) begin errors++; $display("FAIL stall_bubbles: got n=%0d first=%0d last=%0d expected 16 1 19", vn, fv, lv); end
        checks++; if (state_out_a !== ID_STATE) begin errors++; $display("FAIL stall_state: got %h expected %h", state_out_a, ID_STATE); end
    endtask

    task automatic test_ignored;
        int dj, vn, fv, lv;
        logic b0, r0;
        drive_load_a(ID_STATE);
        run_a(1'b0, 0, 6, 8'h00, dj, vn, fv, lv, b0, r0);
        checks++; if (dj != 19) begin errors++; $display("FAIL ign_done_edge: got %0d expected 19", dj); end
        checks++; if (state_out_a !== ID_STATE) begin errors++; $display("FAIL ign_state: got %h expected %h", state_out_a, ID_STATE); end
        @(negedge clk);
        load_a = 1'b1;
        start_a = 1'b1;
        state_in_a = ALT_STATE;
        @(negedge clk);
        load_a = 1'b0;
        start_a = 1'b0;
        checks++; if (state_out_a !== ALT_STATE) begin errors++; $display("FAIL ign_load_prio: got %h expected %h", state_out_a, ALT_STATE); end
        checks++; if (busy_a !== 1'b0 || rnd_rdy_a !== 1'b0 || dbg_a !== 2'd0) begin errors++; $display("FAIL ign_no_start: got busy %b rdy %b fsm %0d expected 0 0 0", busy_a, rnd_rdy_a, dbg_a); end
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL ign_still_idle: got %b expected 0", busy_a); end
    endtask

    task automatic test_reset_mid;
        int dj, vn, fv, lv;
        logic b0, r0;
        logic stayed;
        drive_load_a(ID_STATE);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        rnd_a = 8'h00;
        rnd_vld_a = 1'b1;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rnd_vld_a = 1'b0;
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || rnd_rdy_a !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got busy %b done %b rdy %b expected 0 0 0", busy_a, done_a, rnd_rdy_a); end
        checks++; if (sbox_x_vld_a !== 1'b0 || sbox_x_a !== 12'h000) begin errors++; $display("FAIL rstmid_x: got vld %b x %h expected 0 000", sbox_x_vld_a, sbox_x_a); end
        checks++; if (state_out_a !== '0) begin errors++; $display("FAIL rstmid_state: got %h expected 0", state_out_a); end
        stayed = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (state_out_a !== '0 || busy_a !== 1'b0 || sbox_x_vld_a !== 1'b0) stayed = 1'b0;
        end
        checks++; if (stayed !== 1'b1) begin errors++; $display("FAIL rstmid_no_capture: got state %h expected 0", state_out_a); end
        drive_load_a(ID_STATE);
        run_a(1'b0, 0, -1, 8'h00, dj, vn, fv, lv, b0, r0);
        checks++; if (dj != 19 || state_out_a !== ID_STATE) begin errors++; $display("FAIL rstmid_rerun: got done %0d state %h expected 19 %h", dj, state_out_a, ID_STATE); end
    endtask

    task automatic test_back_to_back;
        int dj, vn, fv, lv;
        logic b0, r0;
        drive_load_a(ID_STATE);
        run_a(1'b0, 0, -1, 8'h3C, dj, vn, fv, lv, b0, r0);
        checks++; if (dj != 19) begin errors++; $display("FAIL b2b_first_done: got %0d expected 19", dj); end
        start_a = 1'b1;
        run_a(1'b1, 0, -1, 8'h3C, dj, vn, fv, lv, b0, r0);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy %b expected 1", b0); end
        checks++; if (dj != 19 || vn != 16) begin errors++; $display("FAIL b2b_second: got done %0d vld %0d expected 19 16", dj, vn); end
        checks++; if ((state_out_a[63:0] ^ state_out_a[127:64] ^ state_out_a[191:128]) !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL b2b_unmasked: got %h expected ffffffffffffffff", state_out_a[63:0] ^ state_out_a[127:64] ^ state_out_a[191:128]);
        end
    endtask

    task automatic test_present;
        logic [63:0] xs [2];
        logic [63:0] ys [2];
        logic [63:0] s0, s1, got;
        int dj;
        xs[0] = 64'h0123_4567_89AB_CDEF; ys[0] = 64'hC56B_90AD_3EF8_4712;
        xs[1] = 64'hFEDC_BA98_7654_3210; ys[1] = 64'h2174_8FE3_DA09_B65C;
        for (int v = 0; v < 2; v++) begin
            s0 = {$urandom, $urandom};
            s1 = {$urandom, $urandom};
            @(negedge clk);
            load_b = 1'b1;
            state_in_b = {xs[v] ^ s0 ^ s1, s1, s0};
            @(negedge clk);
            load_b = 1'b0;
            start_b = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start_b = 1'b0;
            dj = -1;
            for (int j = 0; j < 60 && dj < 0; j++) begin
                if (j > 0) @(negedge clk);
                if (done_b) dj = j;
                rnd_b = 8'($urandom_range(0, 255));
                rnd_vld_b = 1'b1;
            end
            rnd_vld_b = 1'b0;
            got = state_out_b[63:0] ^ state_out_b[127:64] ^ state_out_b[191:128];
            checks++; if (dj != 21) begin errors++; $display("FAIL present_done_edge[%0d]: got %0d expected 21", v, dj); end
            checks++; if (got !== ys[v]) begin errors++; $display("FAIL present_result[%0d]: got %h expected %h", v, got, ys[v]); end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_refresh();
        test_stall();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        test_present();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
